// File: rtl/sata_oob_encoder.sv
// SATA transmit-side OOB encoder: six ALIGN bursts separated by electrical-idle gaps
// (COMINIT/COMRESET or COMWAKE), driving the PHY txelecidle control.
module sata_oob_encoder #(
  parameter int CLKFREQ = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic cominit_req,
  input  logic comwake_req,
  input  logic abort,
  output logic txelecidle,
  output logic busy,
  output logic oobtype,
  output logic done
);

  localparam longint REFFREQ = 1_500_000;

  // Lengths are specified in 1.5 GHz line periods; convert to clk cycles, rounded, min 1.
  function automatic int to_clk_cycles(input longint ref_periods);
    longint r;
    r = (ref_periods * CLKFREQ + REFFREQ / 2) / REFFREQ;
    return (r < 1) ? 1 : int'(r);
  endfunction

  localparam int BURST_LEN   = to_clk_cycles(160);
  localparam int GAPINIT_LEN = to_clk_cycles(480);
  localparam int GAPWAKE_LEN = to_clk_cycles(160);
  localparam int LEN_MAX     = (BURST_LEN > GAPINIT_LEN) ? BURST_LEN : GAPINIT_LEN;
  localparam int LEN_W       = $clog2(LEN_MAX + 1);

  localparam logic [LEN_W-1:0] BURST_LAST   = LEN_W'(BURST_LEN - 1);
  localparam logic [LEN_W-1:0] GAPINIT_LAST = LEN_W'(GAPINIT_LEN - 1);
  localparam logic [LEN_W-1:0] GAPWAKE_LAST = LEN_W'(GAPWAKE_LEN - 1);
  localparam logic [2:0]       LAST_BURST   = 3'd5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    GAP   = 2'd2,
    TAIL  = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic [LEN_W-1:0] len_cnt;
  logic [LEN_W-1:0] len_cnt_next;
  logic [2:0]       burst_cnt;
  logic [2:0]       burst_cnt_next;
  logic             oobtype_next;
  logic             done_next;
  logic [LEN_W-1:0] gap_last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      len_cnt    <= '0;
      burst_cnt  <= '0;
      oobtype    <= 1'b0;
      done       <= 1'b0;
      txelecidle <= 1'b1;
      busy       <= 1'b0;
    end else begin
      state      <= state_next;
      len_cnt    <= len_cnt_next;
      burst_cnt  <= burst_cnt_next;
      oobtype    <= oobtype_next;
      done       <= done_next;
      // Outputs are registered from the next state so they line up with it.
      txelecidle <= (state_next != BURST);
      busy       <= (state_next != IDLE);
    end
  end

  always_comb begin
    state_next     = state;
    len_cnt_next   = len_cnt + LEN_W'(1);
    burst_cnt_next = burst_cnt;
    oobtype_next   = oobtype;
    done_next      = 1'b0;
    gap_last       = oobtype ? GAPWAKE_LAST : GAPINIT_LAST;

    case (state)
      IDLE: begin
        len_cnt_next   = '0;
        burst_cnt_next = '0;
        // The done cycle is still post-sequence; requests seen then are dropped.
        if (!done) begin
          if (cominit_req) begin
            oobtype_next = 1'b0;
            state_next   = BURST;
          end else if (comwake_req) begin
            oobtype_next = 1'b1;
            state_next   = BURST;
          end
        end
      end
      BURST: begin
        if (len_cnt == BURST_LAST) begin
          len_cnt_next = '0;
          state_next   = (burst_cnt < LAST_BURST) ? GAP : TAIL;
        end
      end
      GAP: begin
        if (len_cnt == gap_last) begin
          len_cnt_next   = '0;
          burst_cnt_next = burst_cnt + 3'd1;
          state_next     = BURST;
        end
      end
      TAIL: begin
        if (len_cnt == gap_last) begin
          len_cnt_next = '0;
          state_next   = IDLE;
          done_next    = 1'b1;
        end
      end
      default: begin
        len_cnt_next = '0;
        state_next   = IDLE;
      end
    endcase

    if (abort && (state != IDLE)) begin
      state_next     = IDLE;
      len_cnt_next   = '0;
      burst_cnt_next = '0;
      done_next      = 1'b0;
    end
  end

endmodule
